// File: rtl/spgd_pkg.sv
// Shared types, constants and helpers for the SPGD dither controller.
package spgd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY_P,
    S_MEAS_P,
    S_APPLY_M,
    S_MEAS_M,
    S_UPDATE
  } state_e;

  // Metric format: signed Q16.16.
  localparam int Q_INT_BITS  = 16;
  localparam int Q_FRAC_BITS = 16;

  localparam int DAC_W_DEF = 14;

  // Headroom for metric difference, shifted step and code arithmetic.
  localparam int WIDE_W = 40;

  // x^16+x^14+x^13+x^11+1 with the register shifting toward bit 0.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAP_MASK), s[15:1]};
  endfunction

  function automatic logic signed [WIDE_W-1:0] clamp(input logic signed [WIDE_W-1:0] v,
                                                     input logic signed [WIDE_W-1:0] lo,
                                                     input logic signed [WIDE_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_code(input logic signed [WIDE_W-1:0] v,
                                                        input logic signed [WIDE_W-1:0] code_max);
    return clamp(v, '0, code_max);
  endfunction

endpackage

// File: rtl/spgd_lfsr16.sv
// 16-bit Fibonacci LFSR supplying the dither sign; steps only when advance is high.
module spgd_lfsr16
  import spgd_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        ADC_CLK,
  input  logic        RST,
  input  logic        advance,
  output logic [15:0] state
);
  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = advance ? lfsr_step(state_q) : state_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ADC_CLK) begin
    if (RST) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/spgd_dither_ctrl.sv
// Two-sided SPGD dither controller: applies u+s*d and u-s*d, measures the metric at
// each polarity, then steps u by the shifted metric difference.
module spgd_dither_ctrl
  import spgd_pkg::*;
#(
  parameter int          FLOAT_WIDTH    = Q_INT_BITS + Q_FRAC_BITS,
  parameter int          DAC_WIDTH      = DAC_W_DEF,
  parameter int          SETTLE_CYCLES  = 64,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DEF
) (
  input  logic                   ADC_CLK,
  input  logic                   RST,
  input  logic                   ENABLE,
  input  logic [FLOAT_WIDTH-1:0] METRIC_IN,
  input  logic                   METRIC_VALID,
  input  logic [DAC_WIDTH-1:0]   DITHER_AMP,
  input  logic [4:0]             GAIN_SHIFT,
  input  logic [DAC_WIDTH-1:0]   CODE_INIT,
  output logic                   MEAS_START,
  output logic [DAC_WIDTH-1:0]   DAC_CODE_OUT,
  output logic [15:0]            ITER_COUNT,
  output logic                   BUSY,
  output logic                   ERR
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic signed [WIDE_W-1:0] CODE_MAX = WIDE_W'((64'd1 << DAC_WIDTH) - 64'd1);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [DAC_WIDTH-1:0]           u_q, u_d;
  logic [DAC_WIDTH-1:0]           dac_q, dac_d;
  logic                           s_q, s_d;
  logic signed [FLOAT_WIDTH-1:0]  jp_q, jp_d, jm_q, jm_d;
  logic [15:0]                    iter_q, iter_d;
  logic                           err_q, err_d;
  logic                           meas_start_q, meas_start_d;
  logic                           en_q;
  logic [15:0]                    lfsr_state;
  logic signed [WIDE_W-1:0]       diff_w, step_w, u_w, sd_w;

  spgd_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .ADC_CLK (ADC_CLK),
    .RST     (RST),
    .advance (state_q == S_UPDATE),
    .state   (lfsr_state)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    u_d          = u_q;
    s_d          = s_q;
    jp_d         = jp_q;
    jm_d         = jm_q;
    iter_d       = iter_q;
    err_d        = err_q;
    meas_start_d = 1'b0;

    diff_w = WIDE_W'(jp_q) - WIDE_W'(jm_q);
    step_w = clamp(diff_w >>> GAIN_SHIFT, -CODE_MAX, CODE_MAX);

    unique case (state_q)
      S_IDLE: begin
        if (ENABLE && !en_q) begin
          state_d = S_APPLY_P;
          cnt_d   = '0;
          u_d     = CODE_INIT;
          err_d   = 1'b0;
          s_d     = lfsr_state[0];
        end
      end
      S_APPLY_P, S_APPLY_M: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d      = (state_q == S_APPLY_P) ? S_MEAS_P : S_MEAS_M;
          cnt_d        = '0;
          meas_start_d = 1'b1;
        end
      end
      S_MEAS_P, S_MEAS_M: begin
        // The strobe is only honoured once the request cycle has passed.
        if (METRIC_VALID && !meas_start_q) begin
          if (state_q == S_MEAS_P) begin
            jp_d    = METRIC_IN;
            state_d = S_APPLY_M;
          end else begin
            jm_d    = METRIC_IN;
            state_d = S_UPDATE;
          end
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_UPDATE: begin
        u_w     = WIDE_W'(u_q);
        u_d     = DAC_WIDTH'(sat_code(u_w + (s_q ? step_w : -step_w), CODE_MAX));
        iter_d  = iter_q + 16'd1;
        // Bit 1 now becomes bit 0 after this cycle's LFSR step.
        s_d     = lfsr_state[1];
        state_d = ENABLE ? S_APPLY_P : S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (!ENABLE && state_q != S_IDLE && state_q != S_UPDATE) state_d = S_IDLE;

    u_w  = WIDE_W'(u_d);
    sd_w = s_d ? WIDE_W'(DITHER_AMP) : -WIDE_W'(DITHER_AMP);
    unique case (state_d)
      S_IDLE:             dac_d = u_d;
      S_APPLY_P, S_MEAS_P: dac_d = DAC_WIDTH'(sat_code(u_w + sd_w, CODE_MAX));
      default:            dac_d = DAC_WIDTH'(sat_code(u_w - sd_w, CODE_MAX));
    endcase
  end

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      u_q          <= '0;
      dac_q        <= '0;
      s_q          <= 1'b0;
      jp_q         <= '0;
      jm_q         <= '0;
      iter_q       <= '0;
      err_q        <= 1'b0;
      meas_start_q <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      u_q          <= u_d;
      dac_q        <= dac_d;
      s_q          <= s_d;
      jp_q         <= jp_d;
      jm_q         <= jm_d;
      iter_q       <= iter_d;
      err_q        <= err_d;
      meas_start_q <= meas_start_d;
      en_q         <= ENABLE;
    end
  end

  assign MEAS_START   = meas_start_q;
  assign DAC_CODE_OUT = dac_q;
  assign ITER_COUNT   = iter_q;
  assign BUSY         = (state_q != S_IDLE);
  assign ERR          = err_q;

endmodule

// File: tb/tb_spgd_dither_ctrl.sv
// Self-checking bench for spgd_dither_ctrl against a transaction-level SPGD model.
module tb_spgd_dither_ctrl;
  localparam int CMAX    = 16383;
  localparam int SETTLE  = 64;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst, enable, metric_valid;
  logic [31:0] metric_in;
  logic [13:0] dither_amp, code_init, dac_code;
  logic [4:0]  gain_shift;
  logic        meas_start, busy, err;
  logic [15:0] iter_count;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int          m_u, m_iter;
  logic [15:0] m_lfsr;
  bit          m_s;

  always #5 clk = ~clk;

  spgd_dither_ctrl dut (
    .ADC_CLK      (clk),
    .RST          (rst),
    .ENABLE       (enable),
    .METRIC_IN    (metric_in),
    .METRIC_VALID (metric_valid),
    .DITHER_AMP   (dither_amp),
    .GAIN_SHIFT   (gain_shift),
    .CODE_INIT    (code_init),
    .MEAS_START   (meas_start),
    .DAC_CODE_OUT (dac_code),
    .ITER_COUNT   (iter_count),
    .BUSY         (busy),
    .ERR          (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input longint v);
    if (v < 0) return 0;
    if (v > CMAX) return CMAX;
    return int'(v);
  endfunction

  // Polynomial x^16+x^14+x^13+x^11+1; exponents 16,14,13,11 map to bits 0,2,3,5.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  function automatic int pert(input bit plus);
    longint sd;
    sd = m_s ? longint'(dither_amp) : -longint'(dither_amp);
    return plus ? sat(m_u + sd) : sat(m_u - sd);
  endfunction

  task automatic model_update(input logic signed [31:0] jp, input logic signed [31:0] jm);
    longint diff, step;
    diff = longint'(jp) - longint'(jm);
    step = diff >>> gain_shift;
    if (step > CMAX) step = CMAX;
    if (step < -CMAX) step = -CMAX;
    m_u    = sat(m_u + (m_s ? step : -step));
    m_iter = (m_iter + 1) % 65536;
    m_lfsr = lfsr_adv(m_lfsr);
    m_s    = m_lfsr[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; metric_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_u = 0; m_iter = 0; m_lfsr = 16'hACE1; m_s = 1'b0;
  endtask

  task automatic start();
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    m_u = int'(code_init);
    m_s = m_lfsr[0];
    check("start_busy", busy, 1);
    check("start_err", err, 0);
  endtask

  task automatic wait_meas(output int k);
    k = 0;
    while (!meas_start && k < 200) begin
      tick();
      k++;
    end
  endtask

  // Entered at the first sampled cycle of APPLY_P. mode: 0 full, 1 drop ENABLE in APPLY_M,
  // 2 reset in MEAS_P, 3 drop ENABLE on the UPDATE cycle.
  task automatic run_iter(input logic signed [31:0] jp, input logic signed [31:0] jm,
                          input int mode, input string tag);
    int k;
    check({tag, "_plus_code"}, dac_code, pert(1));
    wait_meas(k);
    check({tag, "_settle_p"}, k, SETTLE);
    if (mode == 2) begin
      rst = 1'b1; enable = 1'b0; metric_valid = 1'b0;
      tick();
      rst = 1'b0;
      check({tag, "_rst_dac"}, dac_code, 0);
      check({tag, "_rst_iter"}, iter_count, 0);
      check({tag, "_rst_busy"}, busy, 0);
      check({tag, "_rst_err"}, err, 0);
      check({tag, "_rst_meas"}, meas_start, 0);
      m_u = 0; m_iter = 0; m_lfsr = 16'hACE1;
      return;
    end
    // A strobe on the request cycle carries a wrong value and must be ignored.
    metric_valid = 1'b1; metric_in = ~jp;
    tick();
    check({tag, "_meas_pulse"}, meas_start, 0);
    metric_valid = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    metric_valid = 1'b1; metric_in = jp;
    tick();
    metric_valid = 1'b0;
    check({tag, "_minus_code"}, dac_code, pert(0));
    if (mode == 1) begin
      enable = 1'b0;
      tick();
      check({tag, "_abort_busy"}, busy, 0);
      check({tag, "_abort_dac"}, dac_code, m_u);
      check({tag, "_abort_iter"}, iter_count, m_iter);
      return;
    end
    wait_meas(k);
    check({tag, "_settle_m"}, k, SETTLE);
    tick();
    repeat ($urandom_range(0, 2)) tick();
    metric_valid = 1'b1; metric_in = jm;
    tick();
    metric_valid = 1'b0;
    check({tag, "_update_hold"}, dac_code, pert(0));
    model_update(jp, jm);
    if (mode == 3) enable = 1'b0;
    tick();
    check({tag, "_iter"}, iter_count, m_iter);
    if (mode == 3) begin
      check({tag, "_stop_busy"}, busy, 0);
      check({tag, "_stop_dac"}, dac_code, m_u);
    end
  endtask

  initial begin
    int k;
    logic signed [31:0] jp, jm;
    rst = 1'b1; enable = 1'b0; metric_valid = 1'b0; metric_in = '0;
    dither_amp = '0; gain_shift = '0; code_init = '0;

    do_reset();
    check("reset_dac", dac_code, 0);
    check("reset_iter", iter_count, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_meas", meas_start, 0);

    // Basic update
    code_init = 14'd8192; dither_amp = 14'd16; gain_shift = 5'd16;
    start();
    check("basic_plus_const", dac_code, 8208);
    run_iter(32'sh0010_0000, 32'sh000C_0000, 0, "basic");
    enable = 1'b0; tick();
    check("basic_u", dac_code, 8196);
    check("basic_iter_const", iter_count, 1);

    // Saturation high
    do_reset();
    code_init = 14'd16380; dither_amp = 14'd16; gain_shift = 5'd0;
    start();
    check("sat_plus_const", dac_code, 16383);
    run_iter(32'sh7FFF_0000, -32'sh7FFF_0000, 0, "sat_hi");
    enable = 1'b0; tick();
    check("sat_u_hi", dac_code, 16383);

    // Saturation low, ENABLE dropped on the UPDATE cycle
    do_reset();
    code_init = 14'd5; dither_amp = 14'd16; gain_shift = 5'd4;
    start();
    run_iter(32'sd7, 32'sd7, 3, "sat_lo");
    check("sat_lo_u", dac_code, 5);

    // Timeout then restart
    do_reset();
    code_init = 14'd1234; dither_amp = 14'd20; gain_shift = 5'd12;
    start();
    wait_meas(k);
    check("to_settle", k, SETTLE);
    k = 0;
    while (busy && k < 5000) begin
      tick();
      k++;
    end
    check("to_cycles", k, TIMEOUT);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_dac", dac_code, m_u);
    start();
    run_iter(32'sh0003_0000, 32'sh0001_0000, 0, "to_restart");

    // Aborts
    do_reset();
    code_init = 14'd3000; dither_amp = 14'd50; gain_shift = 5'd10;
    start();
    run_iter($urandom, $urandom, 1, "abort_m");
    start();
    run_iter($urandom, $urandom, 2, "rst_meas");

    // Sign sequence with equal metrics
    do_reset();
    code_init = 14'($urandom_range(2000, 14000));
    dither_amp = 14'($urandom_range(1, 400));
    gain_shift = 5'($urandom_range(0, 31));
    start();
    for (int i = 0; i < 20; i++) begin
      jp = $urandom;
      run_iter(jp, jp, 0, "seq");
    end
    check("seq_iter", iter_count, 20);
    enable = 1'b0; tick();
    check("seq_u_const", dac_code, code_init);

    // Randomized iterations
    do_reset();
    code_init = 14'($urandom_range(1000, 15000));
    dither_amp = 14'($urandom_range(0, 600));
    start();
    for (int i = 0; i < 8; i++) begin
      gain_shift = 5'($urandom_range(6, 20));
      jp = int'($urandom_range(0, 4194304)) - 2097152;
      jm = int'($urandom_range(0, 4194304)) - 2097152;
      run_iter(jp, jm, (i == 7) ? 3 : 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
